stack_sequencer: RTL
====================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, stack-pointer width in bits.
REQ-002 SHALL have parameter PAGE, default 8'h01, constant high address byte of the stack page.
REQ-003 SHALL have parameter RST_VAL, default 8'hfa, pointer value loaded on reset (low W bits).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port sbin  input  W  parallel load data.
REQ-007 SHALL have port wa  input  1  load pointer from sbin.
REQ-008 SHALL have ports inc, dec  input  1 each  single-step pointer adjust.
REQ-009 SHALL have port start  input  1  begin a multi-byte sequence.
REQ-010 SHALL have port n  input  2  byte count of the sequence (0..3).
REQ-011 SHALL have port dir  input  1  0 = push, 1 = pop.
REQ-012 SHALL have ports sboa, adloa  input  1 each  output enables for sbout, adlout.
REQ-013 SHALL have port sbout  output  W  pointer value when sboa=1, else high-Z.
REQ-014 SHALL have port adlout  output  W  effective address low byte when adloa=1, else high-Z.
REQ-015 SHALL have port adhout  output  8  PAGE when adloa=1, else high-Z.
REQ-016 SHALL have ports busy, step, done, ovf, unf  output  1 each  status (defined below).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FIN.
REQ-018 Register-update priority SHALL be: clr > wa > RUN-sequence step > inc/dec.
REQ-019 IDLE: start=1 with n!=0 SHALL latch dir and cnt=n and move to RUN next cycle; start with n=0 SHALL go directly to FIN.
REQ-020 RUN, push: each cycle effective address = SP, step=1, SP <= SP-1, cnt <= cnt-1.
REQ-021 RUN, pop: each cycle effective address = SP+1 (mod 2^W), step=1, SP <= SP+1, cnt <= cnt-1.
REQ-022 RUN with cnt==1 SHALL transition to FIN; a sequence of n bytes SHALL occupy exactly n RUN cycles.
REQ-023 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL equal 1 in RUN and FIN, 0 in IDLE; step SHALL be 1 only in RUN.
REQ-025 Outside RUN, effective address SHALL equal SP.
REQ-026 start while busy SHALL be ignored; inc/dec while busy SHALL be ignored.
REQ-027 inc and dec both high in IDLE SHALL leave SP unchanged.
REQ-028 Arithmetic SHALL be modulo 2^W (wrap 0 -> all-ones on decrement, all-ones -> 0 on increment).
REQ-029 ovf SHALL set (sticky) when any decrement wraps 0 -> all-ones; unf SHALL set (sticky) when any increment wraps all-ones -> 0.
REQ-030 wa SHALL load SP from sbin, clear ovf and unf, and, if busy, abort to IDLE without asserting done.
REQ-031 Output enables SHALL be combinational and independent of FSM state.

Reset
REQ-032 clr=1 at a posedge SHALL set SP=RST_VAL, state=IDLE, cnt=0, ovf=0, unf=0, done=0, step=0, busy=0, regardless of state (including mid-sequence).
REQ-033 Tri-state outputs SHALL follow enables during and after reset.

Verification
REQ-034 clr, then sboa=1 -> sbout=8'hfa, busy=0, ovf=unf=0.
REQ-035 SP=fa, start n=3 dir=0, adloa=1 -> RUN cycles show adlout fa,f9,f8, adhout=01, step=1 x3; done pulses the next cycle; final SP=f7.
REQ-036 SP=f7, start n=2 dir=1 -> adlout f8,f9; final SP=f9; done one cycle.
REQ-037 wa sbin=00, then dec -> SP=ff, ovf=1; then inc -> SP=00, unf=1; then wa sbin=10 -> ovf=unf=0.
REQ-038 Push n=3 from SP=fa; clr asserted in the 2nd RUN cycle -> next cycle SP=fa, IDLE, done never asserted.
REQ-039 start n=0 -> busy one cycle, done one cycle, SP unchanged, step never asserted.

Source files
------------

// File: rtl/stack_sequencer.sv
// Stack-pointer register with single-step adjust and a multi-byte push/pop sequencer.
// Drives the effective stack address (PAGE:low byte) onto tri-state buses.
module stack_sequencer #(
   parameter int unsigned    W       = 8,
   parameter logic [7:0]     PAGE    = 8'h01,
   parameter logic [W-1:0]   RST_VAL = 'hfa
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] sbin,
   input  logic         wa,
   input  logic         inc,
   input  logic         dec,
   input  logic         start,
   input  logic [1:0]   n,
   input  logic         dir,
   input  logic         sboa,
   input  logic         adloa,
   output logic [W-1:0] sbout,
   output logic [W-1:0] adlout,
   output logic [7:0]   adhout,
   output logic         busy,
   output logic         step,
   output logic         done,
   output logic         ovf,
   output logic         unf
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e       state;
   logic [W-1:0] sp;
   logic [1:0]   cnt;
   logic         dir_q;

   logic [W-1:0] sp_inc, sp_dec, ea;
   logic         sp_zero, sp_ones;

   assign sp_inc  = sp + W'(1);
   assign sp_dec  = sp - W'(1);
   assign sp_zero = (sp == '0);
   assign sp_ones = (sp == '1);

   // A pop reads the slot above the current pointer; everything else addresses SP itself.
   assign ea = (state == StRun && dir_q) ? sp_inc : sp;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= StIdle;
         sp    <= RST_VAL;
         cnt   <= '0;
         dir_q <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         busy  <= 1'b0;
         step  <= 1'b0;
         done  <= 1'b0;
      end else if (wa) begin
         // Load also aborts any sequence in flight, without a done pulse.
         state <= StIdle;
         sp    <= sbin;
         cnt   <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         busy  <= 1'b0;
         step  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  busy <= 1'b1;
                  if (n != 2'd0) begin
                     state <= StRun;
                     cnt   <= n;
                     dir_q <= dir;
                     step  <= 1'b1;
                  end else begin
                     state <= StFin;
                     done  <= 1'b1;
                  end
               end
               if (inc && !dec) begin
                  sp <= sp_inc;
                  if (sp_ones) unf <= 1'b1;
               end else if (dec && !inc) begin
                  sp <= sp_dec;
                  if (sp_zero) ovf <= 1'b1;
               end
            end
            StRun: begin
               if (dir_q) begin
                  sp <= sp_inc;
                  if (sp_ones) unf <= 1'b1;
               end else begin
                  sp <= sp_dec;
                  if (sp_zero) ovf <= 1'b1;
               end
               cnt <= cnt - 2'd1;
               if (cnt == 2'd1) begin
                  state <= StFin;
                  step  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            StFin: begin
               state <= StIdle;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
               step  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign sbout  = sboa  ? sp   : 'z;
   assign adlout = adloa ? ea   : 'z;
   assign adhout = adloa ? PAGE : 'z;

endmodule
